// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types for the parking-lot elevator: FSM states, floor width, queued job record
package elevator_pkg;

  localparam int                 FLOOR_W     = 3;
  localparam logic [FLOOR_W-1:0] GROUND      = 3'd0;
  localparam int                 JOB_PLATE_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_LOAD,
    S_UP,
    S_DROP,
    S_PICK,
    S_DOWN,
    S_EXIT
  } state_e;

  typedef struct packed {
    logic                   is_in;
    logic [JOB_PLATE_W-1:0] plate;
  } job_t;

  // A target of 0 would never be reached going up, so bad allocator floors are pinned into 1..top.
  function automatic logic [FLOOR_W-1:0] clamp_floor(input logic [FLOOR_W-1:0] f, input int top);
    if (f == GROUND) return 3'd1;
    if (int'(f) > top) return FLOOR_W'(top);
    return f;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// rtl/req_fifo.sv - first-word-fall-through request queue; a push into a full queue is dropped even while popping
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i && !full_o) wr_d = wr_q + 1'b1;
    if (pop_i && !empty_o) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - parking-lot elevator sequencer: request queues, arbitration, car motion, slot strobes
// Define PRIORITY_OUT_EN to let the exit queue always win arbitration instead of round-robin.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int NUM_FLOORS  = 7,
  parameter int PLATE_W     = JOB_PLATE_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PLATE_W-1:0] license_plate,
  input  logic               in_mode,
  input  logic               out_mode,
  input  logic               leakage,
  input  logic [2:0]         leakage_floor,
  output logic [PLATE_W-1:0] alloc_plate,
  output logic               alloc_is_in,
  input  logic               alloc_ok,
  input  logic [2:0]         alloc_floor,
  input  logic               alloc_place,
  output logic [7:0]         blocked,
  output logic               store_en,
  output logic               clear_en,
  output logic               exit_en,
  output logic [2:0]         slot_floor,
  output logic               slot_place,
  output logic [PLATE_W-1:0] exit_plate,
  output logic [2:0]         current_floor,
  output logic [PLATE_W-1:0] moving,
  output logic               reject,
  output logic               req_drop,
  output logic               busy
);

  localparam int JOB_W = $bits(job_t);

  state_e             state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d, tgt_q, tgt_d;
  logic               place_q, place_d;
  logic [PLATE_W-1:0] moving_q, moving_d;
  job_t               job_q, job_d;
  logic               sel_out_q, sel_out_d;
  logic [7:0]         blocked_q;
`ifndef PRIORITY_OUT_EN
  logic               rr_q, rr_d;
`endif

  logic in_req, out_req, in_full, in_empty, out_full, out_empty, pop_in, pop_out, at_slot;
  job_t in_wr, out_wr, in_head, out_head, head;

  assign in_req  = in_mode & ~out_mode;
  assign out_req = out_mode & ~in_mode;
  assign in_wr   = '{is_in: 1'b1, plate: license_plate};
  assign out_wr  = '{is_in: 1'b0, plate: license_plate};
  assign pop_in  = (state_q == S_DISPATCH) & ~sel_out_q;
  assign pop_out = (state_q == S_DISPATCH) & sel_out_q;
  assign head    = sel_out_q ? out_head : in_head;

  req_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(JOB_W)) u_in_q (
    .clk_i(clock), .rst_ni(reset), .push_i(in_req), .data_i(in_wr), .pop_i(pop_in),
    .data_o(in_head), .full_o(in_full), .empty_o(in_empty)
  );

  req_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(JOB_W)) u_out_q (
    .clk_i(clock), .rst_ni(reset), .push_i(out_req), .data_i(out_wr), .pop_i(pop_out),
    .data_o(out_head), .full_o(out_full), .empty_o(out_empty)
  );

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    tgt_d     = tgt_q;
    place_d   = place_q;
    moving_d  = moving_q;
    job_d     = job_q;
    sel_out_d = sel_out_q;
`ifndef PRIORITY_OUT_EN
    rr_d      = rr_q;
`endif
    store_en  = 1'b0;
    clear_en  = 1'b0;
    exit_en   = 1'b0;
    reject    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!in_empty || !out_empty) begin
          state_d = S_DISPATCH;
`ifdef PRIORITY_OUT_EN
          sel_out_d = ~out_empty;
`else
          sel_out_d = (!in_empty && !out_empty) ? rr_q : ~out_empty;
`endif
        end
      end
      S_DISPATCH: begin
        job_d = head;
`ifndef PRIORITY_OUT_EN
        rr_d  = ~rr_q;
`endif
        if (!alloc_ok) begin
          reject  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tgt_d   = clamp_floor(alloc_floor, NUM_FLOORS);
          place_d = alloc_place;
          state_d = head.is_in ? S_LOAD : S_UP;
        end
      end
      S_LOAD: begin
        moving_d = job_q.plate;
        state_d  = S_UP;
      end
      S_UP: begin
        floor_d = floor_q + 3'd1;
        if (floor_d == tgt_q) state_d = job_q.is_in ? S_DROP : S_PICK;
      end
      S_DROP: begin
        store_en = 1'b1;
        moving_d = '0;
        state_d  = S_DOWN;
      end
      S_PICK: begin
        clear_en = 1'b1;
        moving_d = job_q.plate;
        state_d  = S_DOWN;
      end
      S_DOWN: begin
        floor_d = floor_q - 3'd1;
        if (floor_d == GROUND) state_d = job_q.is_in ? S_IDLE : S_EXIT;
      end
      S_EXIT: begin
        exit_en  = 1'b1;
        moving_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      floor_q   <= GROUND;
      tgt_q     <= GROUND;
      place_q   <= 1'b0;
      moving_q  <= '0;
      job_q     <= '0;
      sel_out_q <= 1'b0;
`ifndef PRIORITY_OUT_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      tgt_q     <= tgt_d;
      place_q   <= place_d;
      moving_q  <= moving_d;
      job_q     <= job_d;
      sel_out_q <= sel_out_d;
`ifndef PRIORITY_OUT_EN
      rr_q      <= rr_d;
`endif
    end
  end

  // Leak flags are sticky; the job already in flight keeps its latched slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blocked_q <= '0;
    end else if (leakage && leakage_floor != GROUND) begin
      blocked_q[leakage_floor] <= 1'b1;
    end
  end

  assign at_slot       = (state_q == S_DROP) || (state_q == S_PICK);
  assign alloc_plate   = (state_q == S_DISPATCH) ? head.plate : '0;
  assign alloc_is_in   = (state_q == S_DISPATCH) & head.is_in;
  assign slot_floor    = at_slot ? tgt_q : GROUND;
  assign slot_place    = at_slot & place_q;
  assign exit_plate    = ((state_q == S_DROP) || (state_q == S_EXIT)) ? job_q.plate : '0;
  assign req_drop      = (in_req & in_full) | (out_req & out_full);
  assign busy          = (state_q != S_IDLE) | ~in_empty | ~out_empty;
  assign blocked       = blocked_q;
  assign current_floor = floor_q;
  assign moving        = moving_q;

endmodule
